associative_cache_fifo: RTL and testbench
=========================================

// Module: associative_cache_fifo
// PURPOSE
//  Fully associative cache with FIFO replacement in front of a private main memory (MM).
//  Reads are looked up by tag; a miss fetches the word from MM and allocates a line.
//  Writes go through to MM, and update the cached copy on a hit (write-through, no write-allocate).
//  Single clock domain; one access per cycle.
// PARAMETERS
//  TAG_W     12   address/tag width; MM depth = 2**TAG_W words
//  DATA_W    32   word width
//  NUM_LINES 64   cache lines, power of two; FIFO pointer width = $clog2(NUM_LINES)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset
//  tag_num    in   TAG_W   read address (tag)
//  block_in   in   DATA_W  write data
//  write_num  in   TAG_W   write address
//  read_en    in   1       read request, sampled at posedge clk
//  write_en   in   1       write request, sampled at posedge clk
//  block_out  out  DATA_W  read data, registered
// BEHAVIOUR
//  - Reset (reset=0, async): clear all line valid bits and the FIFO pointer; block_out=0.
//    MM contents are not reset.
//  - Read (read_en=1 at posedge): compare tag_num against all valid line tags in parallel.
//    - Hit: block_out <= line data. FIFO pointer and line order are unchanged.
//    - Miss: block_out <= MM[tag_num]. Line[ptr] <= {valid=1, tag_num, MM[tag_num]}.
//      ptr <= ptr+1, wrapping modulo NUM_LINES.
//    - Latency is 1 cycle: data is valid after the posedge that sampled the request.
//  - Write (write_en=1, read_en=0): MM[write_num] <= block_in.
//    - Hit on write_num: the matching line's data <= block_in.
//    - Miss: no allocation, pointer unchanged.
//  - read_en=1 and write_en=1 in the same cycle: the read is performed and the write is ignored.
//  - No request: block_out holds its value and no state changes.
//  - FIFO order: the oldest allocated line is replaced first. Hits never refresh a line's age.
//  - Replacement only overwrites already-valid lines once all NUM_LINES lines are filled,
//    because the pointer fills lines 0..NUM_LINES-1 in order after reset.
//  - A tag is allocated only on a miss, so the cache never holds duplicate tags.
//  - Reset mid-operation aborts the in-flight access. The MM write of that cycle is not guaranteed.
// CONFIGURATION
//  CACHE_STATS_EN defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
//    - Each read hit or miss increments its counter; writes are not counted.
//    - Both counters clear on reset and saturate at all-ones.
//    - A 1-cycle pulse output last_hit reflects the result of the most recent read.
//  Not defined: these ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package cache_pkg:
//    - constants TAG_W, DATA_W, NUM_LINES
//    - typedef line_t {logic valid; logic [TAG_W-1:0] tag; logic [DATA_W-1:0] data;}
//  Sub-module cache_tag_match: combinational parallel compare of one address against all lines.
//    Outputs hit and a one-hot or encoded hit index.
//    Instantiated twice: once for the read address, once for the write address.
//  Top level holds the line array, MM array, FIFO pointer and output register.
// TESTING
//  1. Write MM[i]=i for i=0..99, then read 0..99.
//     -> all misses; block_out==i one cycle after each request; cache then holds tags 36..99.
//  2. Continue with reads 99 down to 1.
//     -> hits for 99..36; misses for 35..1; lines holding 36..70 are evicted.
//  3. Write MM[k]=10*k for k=0..99.
//     -> cache data updated for k in 1..35 and 71..99 only; MM updated for every k.
//     -> reading 50 afterwards returns 500 via a miss.
//  4. Pulse reset low, then read 50, then read 0..99.
//     -> only the second access to 50 hits, returning 500; block_out==0 right after reset.
//  5. Assert read_en and write_en together on an address A that is cached.
//     -> block_out is the old value; MM[A] and the cache line are unchanged.
//  6. With CACHE_STATS_EN defined, run scenario 2 on its own.
//     -> hit_cnt increases by 64 and miss_cnt by 35.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and the cache line record for associative_cache_fifo.
//   TAG_W     : address/tag width, main memory depth is 2**TAG_W words
//   DATA_W    : word width
//   NUM_LINES : number of cache lines (power of two)
//   PTR_W     : FIFO replacement pointer width
//   line_t    : {valid, tag, data} for one cache line
package cache_pkg;
    localparam int TAG_W     = 12;
    localparam int DATA_W    = 32;
    localparam int NUM_LINES = 64;
    localparam int PTR_W     = $clog2(NUM_LINES);
    localparam int MM_DEPTH  = 1 << TAG_W;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;
endpackage

// File: rtl/cache_tag_match.sv
// Combinational parallel compare of one address against every cache line tag.
// Ports:
//   line_vld  in  NUM_LINES          valid bit of each line
//   line_tag  in  NUM_LINES x TAG_W  tag of each line
//   addr      in  TAG_W              address to look up
//   hit       out 1                  some valid line holds addr
//   hit_oh    out NUM_LINES          one-hot matching line
//   hit_idx   out IDX_W              encoded matching line
module cache_tag_match #(
    parameter int NUM_LINES = 64,
    parameter int TAG_W     = 12,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic [NUM_LINES-1:0]            line_vld,
    input  logic [NUM_LINES-1:0][TAG_W-1:0] line_tag,
    input  logic [TAG_W-1:0]                addr,
    output logic                            hit,
    output logic [NUM_LINES-1:0]            hit_oh,
    output logic [IDX_W-1:0]                hit_idx
);
    for (genvar g = 0; g < NUM_LINES; g++) begin : g_cmp
        assign hit_oh[g] = line_vld[g] && (line_tag[g] == addr);
    end

    assign hit = |hit_oh;

    // Tags are never duplicated, so at most one bit is set and an OR-encode suffices.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (hit_oh[i]) hit_idx = hit_idx | IDX_W'(i);
        end
    end
endmodule

// File: rtl/associative_cache_fifo.sv
// Fully associative cache, FIFO replacement, write-through / no write-allocate,
// in front of a private main memory (MM). One access per cycle, 1-cycle read latency.
// Optional feature macro: CACHE_STATS_EN (adds hit_cnt, miss_cnt, last_hit).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   tag_num    in   read address
//   block_in   in   write data
//   write_num  in   write address
//   read_en    in   read request (wins over write_en)
//   write_en   in   write request
//   hit_cnt    out  saturating read-hit count      (CACHE_STATS_EN)
//   miss_cnt   out  saturating read-miss count     (CACHE_STATS_EN)
//   last_hit   out  1 for the cycle after a read hit (CACHE_STATS_EN)
//   block_out  out  registered read data
module associative_cache_fifo
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [TAG_W-1:0]  tag_num,
    input  logic [DATA_W-1:0] block_in,
    input  logic [TAG_W-1:0]  write_num,
    input  logic              read_en,
    input  logic              write_en,
`ifdef CACHE_STATS_EN
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
    output logic              last_hit,
`endif
    output logic [DATA_W-1:0] block_out
);
    line_t                           lines_q [NUM_LINES];
    line_t                           lines_d [NUM_LINES];
    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic [DATA_W-1:0]               block_out_q, block_out_d;
    logic [DATA_W-1:0]               mm [MM_DEPTH];
    logic [DATA_W-1:0]               mm_rdata;
    logic                            mm_we;

    logic [NUM_LINES-1:0]            line_vld;
    logic [NUM_LINES-1:0][TAG_W-1:0] line_tag;
    logic                            rd_hit, wr_hit;
    logic [NUM_LINES-1:0]            rd_oh, wr_oh;
    logic [PTR_W-1:0]                rd_idx, wr_idx;
    logic                            rd_req, wr_req;

    // A simultaneous read swallows the write.
    assign rd_req   = read_en;
    assign wr_req   = write_en && !read_en;
    assign mm_rdata = mm[tag_num];

    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            line_vld[i] = lines_q[i].valid;
            line_tag[i] = lines_q[i].tag;
        end
    end

    cache_tag_match #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W), .IDX_W(PTR_W)) u_rd_match (
        .line_vld (line_vld),
        .line_tag (line_tag),
        .addr     (tag_num),
        .hit      (rd_hit),
        .hit_oh   (rd_oh),
        .hit_idx  (rd_idx)
    );

    cache_tag_match #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W), .IDX_W(PTR_W)) u_wr_match (
        .line_vld (line_vld),
        .line_tag (line_tag),
        .addr     (write_num),
        .hit      (wr_hit),
        .hit_oh   (wr_oh),
        .hit_idx  (wr_idx)
    );

    always_comb begin
        lines_d     = lines_q;
        ptr_d       = ptr_q;
        block_out_d = block_out_q;
        mm_we       = 1'b0;
        if (rd_req) begin
            if (rd_hit) begin
                block_out_d = lines_q[rd_idx].data;
            end else begin
                // Allocate at the FIFO head; the pointer wraps naturally at NUM_LINES.
                block_out_d    = mm_rdata;
                lines_d[ptr_q] = '{valid: 1'b1, tag: tag_num, data: mm_rdata};
                ptr_d          = ptr_q + PTR_W'(1);
            end
        end else if (wr_req) begin
            mm_we = 1'b1;
            if (wr_hit) lines_d[wr_idx].data = block_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINES; i++) lines_q[i] <= '0;
            ptr_q       <= '0;
            block_out_q <= '0;
        end else begin
            lines_q     <= lines_d;
            ptr_q       <= ptr_d;
            block_out_q <= block_out_d;
        end
    end

    // MM contents survive reset.
    always_ff @(posedge clk) begin
        if (mm_we) mm[write_num] <= block_in;
    end

    assign block_out = block_out_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        last_hit_q, last_hit_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        last_hit_d = rd_req && rd_hit;
        if (rd_req) begin
            if (rd_hit) begin
                if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            last_hit_q <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            last_hit_q <= last_hit_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign last_hit = last_hit_q;
`endif
endmodule

// File: tb/tb_associative_cache_fifo.sv
// Directed bench for associative_cache_fifo: fill/evict/write-through/reset/collision.
module tb_associative_cache_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] tag_num, write_num;
    logic [31:0] block_in, block_out;
    logic        read_en, write_en;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
    logic        last_hit;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    associative_cache_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .tag_num   (tag_num),
        .block_in  (block_in),
        .write_num (write_num),
        .read_en   (read_en),
        .write_en  (write_en),
`ifdef CACHE_STATS_EN
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .last_hit  (last_hit),
`endif
        .block_out (block_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic op(input logic re, input logic we, input int ra, input int wa, input int wd);
        @(negedge clk);
        read_en   = re;
        write_en  = we;
        tag_num   = 12'(ra);
        write_num = 12'(wa);
        block_in  = 32'(wd);
        @(posedge clk);
        #1;
        read_en  = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic rd(input int a, input int exp);
        op(1'b1, 1'b0, a, 0, 0);
        chk($sformatf("rd%0d", a), block_out, 32'(exp));
    endtask

    task automatic wr(input int a, input int d);
        op(1'b0, 1'b1, 0, a, d);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("rst_bout", block_out, 32'd0);
`ifdef CACHE_STATS_EN
        chk("rst_hit", hit_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; read_en = 1'b0; write_en = 1'b0;
        tag_num = '0; write_num = '0; block_in = '0;
        #12;
        chk("por_bout", block_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: fill MM, read 0..99 (all misses), cache ends with 36..99
        for (int i = 0; i < 100; i++) wr(i, i);
        chk("wr_hold", block_out, 32'd0);
        for (int i = 0; i < 100; i++) rd(i, i);
`ifdef CACHE_STATS_EN
        chk("s1_hit", hit_cnt, 32'd0);
        chk("s1_miss", miss_cnt, 32'd100);
        chk("s1_last", {31'd0, last_hit}, 32'd0);
`endif
        // idle cycles keep block_out
        op(1'b0, 1'b0, 5, 5, 7);
        op(1'b0, 1'b0, 5, 5, 7);
        chk("idle_hold", block_out, 32'd99);

        // 2: 99..36 hit, 35..1 miss, evicting 36..70
        rd(99, 99);
`ifdef CACHE_STATS_EN
        chk("s2_last_hit", {31'd0, last_hit}, 32'd1);
`endif
        for (int i = 98; i >= 1; i--) rd(i, i);
`ifdef CACHE_STATS_EN
        chk("s2_hit", hit_cnt, 32'd64);
        chk("s2_miss", miss_cnt, 32'd135);
        chk("s2_last_miss", {31'd0, last_hit}, 32'd0);
`endif

        // 3: write-through MM[k]=10k; 50 was evicted so it comes back via a miss
        for (int k = 0; k < 100; k++) wr(k, 10 * k);
        chk("s3_wr_hold", block_out, 32'd1);
        rd(50, 500);
`ifdef CACHE_STATS_EN
        chk("s3_miss", miss_cnt, 32'd136);
`endif
        for (int k = 0; k < 100; k++) rd(k, 10 * k);

        // 4: reset clears lines; second access to 50 is the only hit
        pulse_reset();
        chk("s4_bout", block_out, 32'd0);
        rd(50, 500);
        for (int k = 0; k < 100; k++) rd(k, 10 * k);
`ifdef CACHE_STATS_EN
        chk("s4_hit", hit_cnt, 32'd1);
        chk("s4_miss", miss_cnt, 32'd100);
`endif

        // 5: read+write together on cached 99: read wins, write dropped
        op(1'b1, 1'b1, 99, 99, 32'hDEAD);
        chk("col_bout", block_out, 32'd990);
        rd(99, 990);
        // collision with a different write address must not touch MM
        op(1'b1, 1'b1, 98, 5, 32'hBEEF);
        chk("col2_bout", block_out, 32'd980);
        rd(5, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
